// File: rtl/sram_burst_arb_if.sv
// Row-port bundle shared by the writer, the reader, the burst arbiter and the sram.
// slave = arbiter side; master = requesters plus sram (environment) side.
interface sram_burst_arb_if #(
    parameter int unsigned row_count = 64,
    parameter int unsigned row_width = 1536
);
    localparam int unsigned addr_width = (row_count > 1) ? $clog2(row_count) : 1;
    localparam int unsigned len_width  = addr_width + 1;

    logic                  wr_req;
    logic [addr_width-1:0] wr_base;
    logic [len_width-1:0]  wr_len;
    logic                  wr_ack;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [row_width-1:0]  wr_din;
    logic                  wr_done;

    logic                  rd_req;
    logic [addr_width-1:0] rd_base;
    logic [len_width-1:0]  rd_len;
    logic                  rd_ack;
    logic                  rd_dvalid;
    logic [row_width-1:0]  rd_dout;
    logic                  rd_done;

    logic                  sram_we;
    logic                  sram_rd_en;
    logic [addr_width-1:0] sram_addr;
    logic [row_width-1:0]  sram_din;
    logic [row_width-1:0]  sram_dout;

    modport slave (
        input  wr_req, wr_base, wr_len, wr_valid, wr_din,
        input  rd_req, rd_base, rd_len,
        input  sram_dout,
        output wr_ack, wr_ready, wr_done,
        output rd_ack, rd_dvalid, rd_dout, rd_done,
        output sram_we, sram_rd_en, sram_addr, sram_din
    );

    modport master (
        output wr_req, wr_base, wr_len, wr_valid, wr_din,
        output rd_req, rd_base, rd_len,
        output sram_dout,
        input  wr_ack, wr_ready, wr_done,
        input  rd_ack, rd_dvalid, rd_dout, rd_done,
        input  sram_we, sram_rd_en, sram_addr, sram_din
    );
endinterface

// File: rtl/sram_burst_arb.sv
// Burst arbiter/sequencer sharing one sram row port between the PE writeback writer and the MHA reader.
// Optional feature macro SRAM_ARB_WR_PRIO_EN: fixed writer priority; undefined gives round-robin on ties.
module sram_burst_arb #(
    parameter int unsigned row_count = 64,
    parameter int unsigned row_width = 1536
) (
    input  logic            clk,
    input  logic            rst,
    sram_burst_arb_if.slave bus
);
    localparam int unsigned addr_width = (row_count > 1) ? $clog2(row_count) : 1;
    localparam int unsigned len_width  = addr_width + 1;

    localparam logic [len_width-1:0]  len_max   = len_width'(row_count);
    localparam logic [len_width-1:0]  len_one   = len_width'(1);
    localparam logic [addr_width-1:0] addr_last = addr_width'(row_count - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [addr_width-1:0] cur_addr_q, cur_addr_d;
    logic [len_width-1:0]  rem_q, rem_d;
    logic                  wr_done_q, wr_done_d;
    logic                  rd_last_q, rd_last_d;
    logic                  rd_dvalid_q, rd_dvalid_d;

    logic                  grant_wr, grant_rd;
    logic [len_width-1:0]  wr_len_sat, rd_len_sat;
    logic                  wr_ack_c, rd_ack_c;
    logic                  wr_zero_done_c, rd_zero_done_c;
    logic                  wr_ready_c, sram_we_c, sram_rd_en_c;
    logic [addr_width-1:0] sram_addr_c;
    logic [row_width-1:0]  wr_din_w, sram_dout_w;

    // Row wrap works for any row_count, not only powers of two.
    function automatic logic [addr_width-1:0] next_addr(input logic [addr_width-1:0] a);
        return (a == addr_last) ? '0 : a + addr_width'(1);
    endfunction

    assign wr_len_sat = (bus.wr_len > len_max) ? len_max : bus.wr_len;
    assign rd_len_sat = (bus.rd_len > len_max) ? len_max : bus.rd_len;

`ifdef SRAM_ARB_WR_PRIO_EN
    // Writeback must never stall the PE array: writer always wins in IDLE.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!rst && (state_q == ST_IDLE)) begin
            grant_wr = bus.wr_req;
            grant_rd = bus.rd_req & ~bus.wr_req;
        end
    end
`else
    typedef enum logic {
        GR_WR = 1'b0,
        GR_RD = 1'b1
    } grant_e;

    grant_e last_grant_q, last_grant_d;

    // Round-robin: on a tie the requester not granted last wins.
    always_comb begin
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;
        last_grant_d = last_grant_q;
        if (!rst && (state_q == ST_IDLE)) begin
            grant_wr = bus.wr_req & (~bus.rd_req | (last_grant_q == GR_RD));
            grant_rd = bus.rd_req & ~grant_wr;
        end
        if (grant_wr) begin
            last_grant_d = GR_WR;
        end else if (grant_rd) begin
            last_grant_d = GR_RD;
        end
    end

    // Reset to RD so the writer wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GR_RD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Next-state and sram port control.
    always_comb begin
        state_d        = state_q;
        cur_addr_d     = cur_addr_q;
        rem_d          = rem_q;
        wr_done_d      = 1'b0;
        rd_last_d      = 1'b0;
        wr_ack_c       = 1'b0;
        rd_ack_c       = 1'b0;
        wr_zero_done_c = 1'b0;
        rd_zero_done_c = 1'b0;
        wr_ready_c     = 1'b0;
        sram_we_c      = 1'b0;
        sram_rd_en_c   = 1'b0;
        sram_addr_c    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_wr) begin
                    wr_ack_c = 1'b1;
                    if (wr_len_sat == '0) begin
                        wr_zero_done_c = 1'b1;
                    end else begin
                        state_d    = ST_WR;
                        cur_addr_d = bus.wr_base;
                        rem_d      = wr_len_sat;
                    end
                end else if (grant_rd) begin
                    rd_ack_c = 1'b1;
                    if (rd_len_sat == '0) begin
                        rd_zero_done_c = 1'b1;
                    end else begin
                        state_d    = ST_RD;
                        cur_addr_d = bus.rd_base;
                        rem_d      = rd_len_sat;
                    end
                end
            end
            ST_WR: begin
                // wr_valid gaps hold the address and count.
                wr_ready_c  = 1'b1;
                sram_we_c   = bus.wr_valid;
                sram_addr_c = cur_addr_q;
                if (bus.wr_valid) begin
                    cur_addr_d = next_addr(cur_addr_q);
                    rem_d      = rem_q - len_one;
                    if (rem_q == len_one) begin
                        state_d   = ST_IDLE;
                        wr_done_d = 1'b1;
                    end
                end
            end
            ST_RD: begin
                sram_rd_en_c = 1'b1;
                sram_addr_c  = cur_addr_q;
                cur_addr_d   = next_addr(cur_addr_q);
                rem_d        = rem_q - len_one;
                if (rem_q == len_one) begin
                    state_d   = ST_IDLE;
                    rd_last_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_dvalid_d = sram_rd_en_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            wr_done_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_dvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            wr_done_q   <= wr_done_d;
            rd_last_q   <= rd_last_d;
            rd_dvalid_q <= rd_dvalid_d;
        end
    end

    assign wr_din_w    = bus.wr_din;
    assign sram_dout_w = bus.sram_dout;

    assign bus.wr_ack     = wr_ack_c;
    assign bus.wr_ready   = wr_ready_c;
    assign bus.wr_done    = wr_done_q | wr_zero_done_c;
    assign bus.rd_ack     = rd_ack_c;
    assign bus.rd_dvalid  = rd_dvalid_q;
    assign bus.rd_dout    = sram_dout_w;
    assign bus.rd_done    = rd_last_q | rd_zero_done_c;
    assign bus.sram_we    = sram_we_c;
    assign bus.sram_rd_en = sram_rd_en_c;
    assign bus.sram_addr  = sram_addr_c;
    assign bus.sram_din   = wr_din_w;

endmodule

// File: tb/tb_sram_burst_arb.sv
// Directed bench for sram_burst_arb: per-cycle vector table plus tie, saturation and mid-burst reset sequences.
module tb_sram_burst_arb;
    localparam int unsigned RC = 64;
    localparam int unsigned RW = 16;
    localparam int NV = 34;

    logic clk;
    logic rst;

    sram_burst_arb_if #(.row_count(RC), .row_width(RW)) bus ();

    sram_burst_arb #(.row_count(RC), .row_width(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple sram model: synchronous write, registered 1-cycle read.
    logic [RW-1:0] mem [0:RC-1];
    logic [RW-1:0] mem_dout;
    always @(posedge clk) begin
        if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_din;
        if (bus.sram_rd_en) mem_dout <= mem[bus.sram_addr];
    end
    assign bus.sram_dout = mem_dout;

    typedef struct {
        logic        rst;
        logic        wr_req;
        logic [5:0]  wr_base;
        logic [6:0]  wr_len;
        logic        wr_valid;
        logic [15:0] wr_din;
        logic        rd_req;
        logic [5:0]  rd_base;
        logic [6:0]  rd_len;
        logic [7:0]  e_flags;   // {wr_ack,wr_ready,wr_done,rd_ack,rd_dvalid,rd_done,sram_we,sram_rd_en}
        logic [5:0]  e_addr;
        logic [15:0] e_dout;    // checked only when rd_dvalid expected
    } vec_t;

    vec_t vec [NV];
    int checks;
    int errors;

    function automatic vec_t mk(input logic r, input logic wq, input int wb, input int wl, input logic wv,
                                input logic [15:0] wd, input logic rq, input int rb, input int rl,
                                input logic [7:0] ef, input int ea, input logic [15:0] ed);
        vec_t v;
        v.rst = r; v.wr_req = wq; v.wr_base = 6'(wb); v.wr_len = 7'(wl); v.wr_valid = wv; v.wr_din = wd;
        v.rd_req = rq; v.rd_base = 6'(rb); v.rd_len = 7'(rl);
        v.e_flags = ef; v.e_addr = 6'(ea); v.e_dout = ed;
        return v;
    endfunction

    function automatic logic [7:0] obs_flags();
        return {bus.wr_ack, bus.wr_ready, bus.wr_done, bus.rd_ack,
                bus.rd_dvalid, bus.rd_done, bus.sram_we, bus.sram_rd_en};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ok, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_gr [4];
        int gr [4];
        int n;
        int overlap;
        int sat_cnt;
        logic seen;
        logic a;
        logic [7:0] f;
        logic ok;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.wr_req = 0; bus.wr_base = '0; bus.wr_len = '0; bus.wr_valid = 0; bus.wr_din = '0;
        bus.rd_req = 0; bus.rd_base = '0; bus.rd_len = '0;
        step();

        //           rst wq wb  wl wv din      rq rb  rl flags        addr dout
        vec[0]  = mk(1, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00000000, 0,  16'h0000);
        vec[1]  = mk(0, 1, 5,  3, 1, 16'h0000, 0, 0,  0, 8'b10000000, 0,  16'h0000);
        vec[2]  = mk(0, 0, 0,  0, 1, 16'h1005, 0, 0,  0, 8'b01000010, 5,  16'h0000);
        vec[3]  = mk(0, 0, 0,  0, 1, 16'h1006, 0, 0,  0, 8'b01000010, 6,  16'h0000);
        vec[4]  = mk(0, 0, 0,  0, 1, 16'h1007, 0, 0,  0, 8'b01000010, 7,  16'h0000);
        vec[5]  = mk(0, 0, 0,  0, 0, 16'h0000, 1, 5,  3, 8'b00110000, 0,  16'h0000);
        vec[6]  = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00000001, 5,  16'h0000);
        vec[7]  = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00001001, 6,  16'h1005);
        vec[8]  = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00001001, 7,  16'h1006);
        vec[9]  = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00001100, 0,  16'h1007);
        vec[10] = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00000000, 0,  16'h0000);
        vec[11] = mk(0, 1, 62, 4, 1, 16'h0000, 0, 0,  0, 8'b10000000, 0,  16'h0000);
        vec[12] = mk(0, 0, 0,  0, 1, 16'h103E, 0, 0,  0, 8'b01000010, 62, 16'h0000);
        vec[13] = mk(0, 0, 0,  0, 1, 16'h103F, 0, 0,  0, 8'b01000010, 63, 16'h0000);
        vec[14] = mk(0, 0, 0,  0, 1, 16'h1000, 0, 0,  0, 8'b01000010, 0,  16'h0000);
        vec[15] = mk(0, 0, 0,  0, 1, 16'h1001, 0, 0,  0, 8'b01000010, 1,  16'h0000);
        vec[16] = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00100000, 0,  16'h0000);
        vec[17] = mk(0, 1, 10, 3, 1, 16'h0000, 0, 0,  0, 8'b10000000, 0,  16'h0000);
        vec[18] = mk(0, 0, 0,  0, 1, 16'h100A, 0, 0,  0, 8'b01000010, 10, 16'h0000);
        vec[19] = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b01000000, 11, 16'h0000);
        vec[20] = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b01000000, 11, 16'h0000);
        vec[21] = mk(0, 0, 0,  0, 1, 16'h100B, 0, 0,  0, 8'b01000010, 11, 16'h0000);
        vec[22] = mk(0, 0, 0,  0, 1, 16'h100C, 0, 0,  0, 8'b01000010, 12, 16'h0000);
        vec[23] = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00100000, 0,  16'h0000);
        vec[24] = mk(0, 0, 0,  0, 0, 16'h0000, 1, 3,  0, 8'b00010100, 0,  16'h0000);
        vec[25] = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00000000, 0,  16'h0000);
        vec[26] = mk(0, 1, 9,  0, 0, 16'h0000, 0, 0,  0, 8'b10100000, 0,  16'h0000);
        vec[27] = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00000000, 0,  16'h0000);
        vec[28] = mk(0, 0, 0,  0, 0, 16'h0000, 1, 63, 2, 8'b00010000, 0,  16'h0000);
        vec[29] = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00000001, 63, 16'h0000);
        vec[30] = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00001001, 0,  16'h103F);
        vec[31] = mk(0, 1, 20, 1, 1, 16'h0000, 0, 0,  0, 8'b10001100, 0,  16'h1000);
        vec[32] = mk(0, 0, 0,  0, 1, 16'h1014, 0, 0,  0, 8'b01000010, 20, 16'h0000);
        vec[33] = mk(0, 0, 0,  0, 0, 16'h0000, 0, 0,  0, 8'b00100000, 0,  16'h0000);

        for (int i = 0; i < NV; i++) begin
            rst = vec[i].rst;
            bus.wr_req = vec[i].wr_req; bus.wr_base = vec[i].wr_base; bus.wr_len = vec[i].wr_len;
            bus.wr_valid = vec[i].wr_valid; bus.wr_din = vec[i].wr_din;
            bus.rd_req = vec[i].rd_req; bus.rd_base = vec[i].rd_base; bus.rd_len = vec[i].rd_len;
            @(negedge clk);
            f = obs_flags();
            ok = (f === vec[i].e_flags) && (bus.sram_addr === vec[i].e_addr) &&
                 (!vec[i].e_flags[3] || (bus.rd_dout === vec[i].e_dout));
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL vec%0d flags=%b addr=%0d dout=%h required flags=%b addr=%0d dout=%h",
                         i, f, bus.sram_addr, bus.rd_dout, vec[i].e_flags, vec[i].e_addr, vec[i].e_dout);
            end
            step();
        end

        // Tie: both requesters held continuously after a fresh reset.
`ifdef SRAM_ARB_WR_PRIO_EN
        exp_gr[0] = 0; exp_gr[1] = 0; exp_gr[2] = 0; exp_gr[3] = 0;
`else
        exp_gr[0] = 0; exp_gr[1] = 1; exp_gr[2] = 0; exp_gr[3] = 1;
`endif
        rst = 1'b1; bus.wr_req = 0; bus.rd_req = 0; bus.wr_valid = 0;
        step();
        rst = 1'b0;
        bus.wr_req = 1; bus.wr_base = 6'd30; bus.wr_len = 7'd1; bus.wr_valid = 1; bus.wr_din = 16'h2222;
        bus.rd_req = 1; bus.rd_base = 6'd40; bus.rd_len = 7'd1;
        n = 0;
        overlap = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (bus.sram_we && bus.sram_rd_en) overlap++;
            if (bus.wr_ack && n < 4) begin gr[n] = 0; n++; end
            else if (bus.rd_ack && n < 4) begin gr[n] = 1; n++; end
            step();
        end
        bus.wr_req = 0; bus.rd_req = 0; bus.wr_valid = 0;
        check("tie_grant_count", n == 4, n, 4);
        for (int g = 0; g < 4; g++) begin
            if (g < n) check($sformatf("tie_grant%0d(0=wr,1=rd)", g), gr[g] == exp_gr[g], gr[g], exp_gr[g]);
        end
        check("we_rd_en_overlap", overlap == 0, overlap, 0);

        // Length above row_count saturates to row_count reads.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rd_req = 1; bus.rd_base = 6'd0; bus.rd_len = 7'd100;
        sat_cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            a = bus.rd_ack;
            if (bus.sram_rd_en) sat_cnt++;
            if (bus.rd_done) begin seen = 1'b1; break; end
            step();
            if (a) bus.rd_req = 0;
        end
        step();
        check("sat_rd_done_seen", seen, int'(seen), 1);
        check("sat_rd_en_cycles", sat_cnt == 64, sat_cnt, 64);

        // Reset during an RD burst aborts it without rd_done.
        bus.rd_req = 1; bus.rd_base = 6'd0; bus.rd_len = 7'd10;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.rd_ack) begin seen = 1'b1; break; end
            step();
        end
        check("abort_rd_ack", seen, int'(seen), 1);
        step();
        bus.rd_req = 0;
        step();
        step();
        @(negedge clk);
        check("abort_rd_active", bus.sram_rd_en === 1'b1, int'(bus.sram_rd_en), 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_rd_en_cleared", bus.sram_rd_en === 1'b0, int'(bus.sram_rd_en), 0);
        check("abort_dvalid_cleared", bus.rd_dvalid === 1'b0, int'(bus.rd_dvalid), 0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            @(negedge clk);
            if (bus.rd_done !== 1'b0 || bus.rd_dvalid !== 1'b0) seen = 1'b1;
        end
        check("abort_no_rd_done", !seen, int'(seen), 0);
        step();
        bus.rd_req = 1; bus.rd_base = 6'd2; bus.rd_len = 7'd1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.rd_ack) begin seen = 1'b1; break; end
            step();
        end
        check("post_reset_rd_ack", seen, int'(seen), 1);
        step();
        bus.rd_req = 0;
        @(negedge clk);
        check("post_reset_rd_en", bus.sram_rd_en === 1'b1, int'(bus.sram_rd_en), 1);
        check("post_reset_rd_addr", bus.sram_addr === 6'd2, int'(bus.sram_addr), 2);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
